// File: rtl/pokemaze_pkg.sv
// Shared types and screen/map geometry for the pokemaze sprite pipeline.
package pokemaze_pkg;

  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int TILE_SHIFT = 5;
  localparam int MAP_W      = SCREEN_W >> TILE_SHIFT;
  localparam int MAP_H      = SCREEN_H >> TILE_SHIFT;

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_L,
    DIR_R,
    DIR_U,
    DIR_D
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_P0,
    ST_P1,
    ST_P2,
    ST_WAIT,
    ST_DECIDE,
    ST_BOUNCE
  } collide_state_t;

  // Facing inputs are nominally one-hot; resolve overlaps as L > R > U > D.
  function automatic dir_t pick_dir(input logic l, input logic r,
                                    input logic u, input logic d);
    if (l)      return DIR_L;
    else if (r) return DIR_R;
    else if (u) return DIR_U;
    else if (d) return DIR_D;
    else        return DIR_NONE;
  endfunction

endpackage

// File: rtl/maze_probe_gen.sv
// Combinational probe-point generator: latched sprite position/direction and a
// probe index give the wall-map ROM address and an off-map flag.
module maze_probe_gen
  import pokemaze_pkg::*;
#(
  parameter int SPR_W      = 20,
  parameter int SPR_H      = 20,
  parameter int TILE_SHIFT = pokemaze_pkg::TILE_SHIFT,
  parameter int MAP_W      = pokemaze_pkg::MAP_W,
  parameter int MAP_H      = pokemaze_pkg::MAP_H
) (
  input  logic [9:0] xpos,
  input  logic [9:0] ypos,
  input  logic [2:0] dir,
  input  logic [1:0] idx,
  output logic [8:0] map_addr,
  output logic       offmap
);

  localparam logic [10:0] X_LIM = 11'(MAP_W << TILE_SHIFT);
  localparam logic [10:0] Y_LIM = 11'(MAP_H << TILE_SHIFT);

  logic [10:0] x11, y11;
  logic [10:0] along_x, along_y;
  logic [10:0] px, py;
  logic [4:0]  tile_x, tile_y;

  assign x11 = {1'b0, xpos};
  assign y11 = {1'b0, ypos};

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the case can leave a value held and infer a latch.
  always_comb begin
    along_x = 11'd0;
    along_y = 11'd0;
    case (idx)
      2'd1: begin
        along_x = 11'(SPR_W / 2);
        along_y = 11'(SPR_H / 2);
      end
      2'd2: begin
        along_x = 11'(SPR_W);
        along_y = 11'(SPR_H);
      end
      default: ;
    endcase
  end

  always_comb begin
    px = x11;
    py = y11;
    case (dir_t'(dir))
      DIR_R: begin
        px = x11 + 11'(SPR_W + 1);
        py = y11 + along_y;
      end
      DIR_L: begin
        px = x11 - 11'd1;
        py = y11 + along_y;
      end
      DIR_D: begin
        px = x11 + along_x;
        py = y11 + 11'(SPR_H + 1);
      end
      DIR_U: begin
        px = x11 + along_x;
        py = y11 - 11'd1;
      end
      default: ;
    endcase
  end

  // A negative coordinate wraps to >= 1024 in 11 bits, so one unsigned
  // compare per axis covers both the low and the high map edge.
  assign offmap = (px >= X_LIM) || (py >= Y_LIM);

  assign tile_x = px[TILE_SHIFT +: 5];
  assign tile_y = py[TILE_SHIFT +: 5];

  assign map_addr = offmap ? 9'd0
                           : 9'(tile_y) * 9'(MAP_W) + 9'(tile_x);

endmodule

// File: rtl/maze_collision.sv
// Wall-collision stage: probes the wall map at the sprite's leading edge on each
// frame tick and drives bounce requests. Optional hit counter: COLLIDE_HITCNT_EN.
module maze_collision
  import pokemaze_pkg::*;
#(
  parameter int SPR_W         = 20,
  parameter int SPR_H         = 20,
  parameter int TILE_SHIFT    = pokemaze_pkg::TILE_SHIFT,
  parameter int MAP_W         = pokemaze_pkg::MAP_W,
  parameter int MAP_H         = pokemaze_pkg::MAP_H,
  parameter int BOUNCE_FRAMES = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       spr_on,
  input  logic [9:0] sprite_xpos,
  input  logic [9:0] sprite_ypos,
  input  logic       L,
  input  logic       R,
  input  logic       U,
  input  logic       D,
  output logic [8:0] map_addr,
  input  logic       map_wall,
  output logic       bnceL,
  output logic       bnceR,
  output logic       bnceU,
  output logic       bnceD,
  output logic       busy,
  output logic [7:0] hit_cnt
);

  localparam logic [7:0] BOUNCE_INIT = 8'(BOUNCE_FRAMES);

  collide_state_t state;
  dir_t           dir_q;
  dir_t           dir_in;
  logic [9:0]     x_q, y_q;
  logic           frame_q;
  logic           tick;
  logic [7:0]     bounce_cnt;
  logic           hit_acc;
  logic           off_q;
  logic [1:0]     probe_idx;
  logic [8:0]     probe_addr;
  logic           probe_off;

  assign tick   = frame_clk & ~frame_q;
  assign dir_in = pick_dir(L, R, U, D);

  always_comb begin
    probe_idx = 2'd0;
    case (state)
      ST_P1:   probe_idx = 2'd1;
      ST_P2:   probe_idx = 2'd2;
      default: ;
    endcase
  end

  maze_probe_gen #(
    .SPR_W      (SPR_W),
    .SPR_H      (SPR_H),
    .TILE_SHIFT (TILE_SHIFT),
    .MAP_W      (MAP_W),
    .MAP_H      (MAP_H)
  ) u_probe_gen (
    .xpos     (x_q),
    .ypos     (y_q),
    .dir      (dir_q),
    .idx      (probe_idx),
    .map_addr (probe_addr),
    .offmap   (probe_off)
  );

  assign map_addr = (state == ST_P0 || state == ST_P1 || state == ST_P2)
                    ? probe_addr : 9'd0;

  // NOTE: all state here updates with non-blocking assignments so every
  // register samples the pre-edge values of the others, as real flops do.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= ST_IDLE;
      frame_q    <= 1'b0;
      x_q        <= '0;
      y_q        <= '0;
      dir_q      <= DIR_NONE;
      hit_acc    <= 1'b0;
      off_q      <= 1'b0;
      bounce_cnt <= '0;
      busy       <= 1'b0;
      bnceL      <= 1'b0;
      bnceR      <= 1'b0;
      bnceU      <= 1'b0;
      bnceD      <= 1'b0;
    end else begin
      frame_q <= frame_clk;
      if (!spr_on) begin
        state      <= ST_IDLE;
        busy       <= 1'b0;
        bounce_cnt <= '0;
        bnceL      <= 1'b0;
        bnceR      <= 1'b0;
        bnceU      <= 1'b0;
        bnceD      <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (tick && bounce_cnt == 8'd0 && dir_in != DIR_NONE) begin
              x_q     <= sprite_xpos;
              y_q     <= sprite_ypos;
              dir_q   <= dir_in;
              hit_acc <= 1'b0;
              busy    <= 1'b1;
              state   <= ST_P0;
            end
          end
          ST_P0: begin
            off_q <= probe_off;
            state <= ST_P1;
          end
          // ROM data for the previous probe is valid now; an off-map probe
          // forces the hit whatever the ROM returned for that slot.
          ST_P1: begin
            hit_acc <= hit_acc | off_q | map_wall;
            off_q   <= probe_off;
            state   <= ST_P2;
          end
          ST_P2: begin
            hit_acc <= hit_acc | off_q | map_wall;
            off_q   <= probe_off;
            state   <= ST_WAIT;
          end
          ST_WAIT: begin
            hit_acc <= hit_acc | off_q | map_wall;
            state   <= ST_DECIDE;
          end
          ST_DECIDE: begin
            busy <= 1'b0;
            if (hit_acc) begin
              case (dir_q)
                DIR_R:   bnceL <= 1'b1;
                DIR_L:   bnceR <= 1'b1;
                DIR_D:   bnceU <= 1'b1;
                DIR_U:   bnceD <= 1'b1;
                default: ;
              endcase
              bounce_cnt <= BOUNCE_INIT;
              state      <= ST_BOUNCE;
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_BOUNCE: begin
            if (tick) begin
              if (bounce_cnt <= 8'd1) begin
                bounce_cnt <= '0;
                bnceL      <= 1'b0;
                bnceR      <= 1'b0;
                bnceU      <= 1'b0;
                bnceD      <= 1'b0;
                state      <= ST_IDLE;
              end else begin
                bounce_cnt <= bounce_cnt - 8'd1;
              end
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

`ifdef COLLIDE_HITCNT_EN
  logic decide_hit;

  assign decide_hit = spr_on && state == ST_DECIDE && hit_acc;

  // Deliberately untouched by spr_on: only Reset clears the running total.
  always_ff @(posedge Clk) begin
    if (Reset)
      hit_cnt <= '0;
    else if (decide_hit && hit_cnt != 8'hFF)
      hit_cnt <= hit_cnt + 8'd1;
  end
`else
  assign hit_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_maze_collision.sv
// Self-checking bench for maze_collision: directed corner cases plus random
// scans checked against a geometric reference model of the probe rules.
`timescale 1ns/1ps
module tb_maze_collision;

  localparam int SPR_W = 20;
  localparam int SPR_H = 20;
  localparam int BF    = 8;
  localparam int SCR_W = 640;
  localparam int SCR_H = 480;
  localparam int NTILE = 300;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       spr_on;
  logic [9:0] sprite_xpos;
  logic [9:0] sprite_ypos;
  logic       L, R, U, D;
  logic [8:0] map_addr;
  logic       map_wall;
  logic       bnceL, bnceR, bnceU, bnceD;
  logic       busy;
  logic [7:0] hit_cnt;

  bit rom [NTILE];
  int n_checks = 0;
  int n_pass   = 0;
  int hc_model = 0;

  maze_collision dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .spr_on      (spr_on),
    .sprite_xpos (sprite_xpos),
    .sprite_ypos (sprite_ypos),
    .L           (L),
    .R           (R),
    .U           (U),
    .D           (D),
    .map_addr    (map_addr),
    .map_wall    (map_wall),
    .bnceL       (bnceL),
    .bnceR       (bnceR),
    .bnceU       (bnceU),
    .bnceD       (bnceD),
    .busy        (busy),
    .hit_cnt     (hit_cnt)
  );

  always #5 Clk = ~Clk;

  // Wall-map ROM with one clock of read latency.
  always @(posedge Clk)
    map_wall <= (int'(map_addr) < NTILE) ? rom[map_addr] : 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  function automatic int bn();
    return int'({bnceL, bnceR, bnceU, bnceD});
  endfunction

  function automatic int exp_hitcnt();
`ifdef COLLIDE_HITCNT_EN
    return hc_model;
`else
    return 0;
`endif
  endfunction

  // 0 none, 1 L, 2 R, 3 U, 4 D; dirs packs {L,R,U,D}.
  function automatic int model_dir(input logic [3:0] dirs);
    if (dirs[3]) return 1;
    if (dirs[2]) return 2;
    if (dirs[1]) return 3;
    if (dirs[0]) return 4;
    return 0;
  endfunction

  function automatic void probe_pt(input int dir, input int x, input int y,
                                   input int k, output int px, output int py);
    int ax, ay;
    ax = (k == 0) ? 0 : (k == 1) ? SPR_W / 2 : SPR_W;
    ay = (k == 0) ? 0 : (k == 1) ? SPR_H / 2 : SPR_H;
    px = x;
    py = y;
    case (dir)
      1: begin px = x - 1;         py = y + ay; end
      2: begin px = x + SPR_W + 1; py = y + ay; end
      3: begin px = x + ax;        py = y - 1;  end
      4: begin px = x + ax;        py = y + SPR_H + 1; end
      default: ;
    endcase
  endfunction

  function automatic bit is_off(input int px, input int py);
    return px < 0 || px >= SCR_W || py < 0 || py >= SCR_H;
  endfunction

  function automatic int tile_addr(input int px, input int py);
    return (py / 32) * 20 + (px / 32);
  endfunction

  // Bounce is opposite to travel; encoding {L,R,U,D}.
  function automatic int bounce_of(input int dir);
    case (dir)
      1: return 4'b0100;
      2: return 4'b1000;
      3: return 4'b0001;
      4: return 4'b0010;
      default: return 0;
    endcase
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < NTILE; i++) rom[i] = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    step();
    Reset    = 1'b0;
    hc_model = 0;
  endtask

  // One scan from tick to decision, optionally followed by the full bounce hold.
  task automatic run_scan(input int x, input int y, input logic [3:0] dirs,
                          input bit extra, input bit scramble, input bit do_bounce,
                          output bit hit);
    int dir, exp_b;
    int px [3];
    int py [3];
    dir = model_dir(dirs);
    hit = 1'b0;
    for (int k = 0; k < 3; k++) begin
      probe_pt(dir, x, y, k, px[k], py[k]);
      if (dir != 0 && (is_off(px[k], py[k]) || rom[tile_addr(px[k], py[k])]))
        hit = 1'b1;
    end
    exp_b = hit ? bounce_of(dir) : 0;

    sprite_xpos = 10'(x);
    sprite_ypos = 10'(y);
    {L, R, U, D} = dirs;
    spr_on    = 1'b1;
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    if (scramble) {L, R, U, D} = 4'($urandom);

    if (dir == 0) begin
      check("nodir_busy", busy, 0);
      repeat (5) step();
      check("nodir_bnce", bn(), 0);
      return;
    end

    for (int k = 0; k < 3; k++) begin
      check($sformatf("busy_p%0d", k), busy, 1);
      if (!is_off(px[k], py[k]))
        check($sformatf("addr_p%0d", k), map_addr, tile_addr(px[k], py[k]));
      if (extra && k == 1) frame_clk = 1'b1;
      if (extra && k == 2) frame_clk = 1'b0;
      step();
    end
    check("busy_wait", busy, 1);
    step();
    check("busy_decide", busy, 1);
    check("bnce_early", bn(), 0);
    step();
    check("busy_done", busy, 0);
    check("bnce_rise", bn(), exp_b);
    if (hit && hc_model < 255) hc_model++;
    check("hit_cnt", hit_cnt, exp_hitcnt());
    step();
    check("no_requeue", busy, 0);

    if (hit && do_bounce) begin
      for (int t = 1; t <= BF; t++) begin
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        check($sformatf("hold_t%0d", t), bn(), (t < BF) ? exp_b : 0);
        check("hold_busy", busy, 0);
        step();
      end
    end
  endtask

  initial begin
    bit hit;
    Reset       = 1'b1;
    frame_clk   = 1'b0;
    spr_on      = 1'b1;
    sprite_xpos = '0;
    sprite_ypos = '0;
    {L, R, U, D} = 4'b0;
    clear_rom();
    do_reset();

    check("rst_busy", busy, 0);
    check("rst_bnce", bn(), 0);
    check("rst_addr", map_addr, 0);
    check("rst_hitcnt", hit_cnt, 0);

    // Open corridor, then a right-hand wall (probe x=351 sits in tile column 10).
    run_scan(336, 100, 4'b0100, 1'b0, 1'b0, 1'b1, hit);
    check("corridor_nohit", hit, 0);
    rom[3*20 + 10] = 1'b1;
    rom[3*20 + 11] = 1'b1;
    run_scan(330, 100, 4'b0100, 1'b0, 1'b0, 1'b1, hit);
    check("rwall_hit", hit, 1);

    // Top edge is off-map regardless of ROM contents.
    clear_rom();
    run_scan(100, 0, 4'b0010, 1'b0, 1'b0, 1'b1, hit);

    // Abort mid-scan with spr_on.
    sprite_xpos = 10'd100;
    sprite_ypos = 10'd0;
    {L, R, U, D} = 4'b0010;
    frame_clk = 1'b1;
    step();
    frame_clk = 1'b0;
    step();
    spr_on = 1'b0;
    step();
    check("abort_busy", busy, 0);
    check("abort_bnce", bn(), 0);
    spr_on = 1'b1;
    step();
    run_scan(100, 0, 4'b0010, 1'b0, 1'b0, 1'b1, hit);

    // Reset during BOUNCE, then an immediate fresh scan must not be blocked.
    run_scan(100, 0, 4'b0010, 1'b0, 1'b0, 1'b0, hit);
    repeat (2) begin
      frame_clk = 1'b1;
      step();
      frame_clk = 1'b0;
      step();
    end
    check("mid_bounce", bn(), 4'b0001);
    do_reset();
    check("rstb_bnce", bn(), 0);
    check("rstb_busy", busy, 0);
    check("rstb_addr", map_addr, 0);
    check("rstb_hitcnt", hit_cnt, 0);
    run_scan(100, 0, 4'b0010, 1'b0, 1'b0, 1'b1, hit);

    // L=R=1 with a wall only on the left, plus a dropped tick during P1.
    clear_rom();
    rom[6*20 + 6] = 1'b1;
    run_scan(224, 200, 4'b1100, 1'b1, 1'b1, 1'b1, hit);
    check("prio_hit", hit, 1);

    // Randomized scans.
    for (int n = 0; n < 150; n++) begin
      int x, y;
      for (int i = 0; i < NTILE; i++) rom[i] = ($urandom_range(0, 3) == 0);
      x = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 639);
      y = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 479);
      run_scan(x, y, 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0), hit);
      // Clear any pending bounce via spr_on so the next scan starts clean.
      spr_on = 1'b0;
      step();
      spr_on = 1'b1;
      check("rand_clear", bn(), 0);
    end

    // Hit counter saturation: spr_on clears the bounce but not the count.
    do_reset();
    for (int n = 0; n < 260; n++) begin
      run_scan(100, 0, 4'b0010, 1'b0, 1'b0, 1'b0, hit);
      spr_on = 1'b0;
      step();
      spr_on = 1'b1;
    end
    check("hitcnt_final", hit_cnt, exp_hitcnt());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
